// File: rtl/psum_requant.sv
// Partial-sum accumulator and requantizer: sums acc_len PE terms, multiplies, rounds, shifts, clamps to uint8 (zp 128).
// Optional build macro PSUM_REQUANT_RELU_EN raises the lower clamp bound to the zero point.
module psum_requant #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic signed [31:0] psum_in,
  input  logic               psum_valid,
  output logic               psum_ready,
  input  logic [LEN_W-1:0]   acc_len,
  input  logic [15:0]        scale,
  input  logic [4:0]         shift,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               sat
);
  localparam int PW = ACC_W + 17;

  typedef enum logic [1:0] {ACC, MUL, RND, EMIT} state_t;
  state_t state, state_nxt;

  logic signed [ACC_W-1:0] acc;
  logic [LEN_W-1:0]        count, len_q, len_eff, len_tgt;
  logic [15:0]             scale_q;
  logic [4:0]              shift_q;
  logic signed [PW-1:0]    product;
  logic                    accept, first, last;
  logic signed [PW:0]      rnd_bias, rnd_sum, r;
  logic                    clamp_hi, clamp_lo;
  logic [7:0]              v8;

  assign psum_ready = (state == ACC) && !rst;
  assign accept     = psum_valid && psum_ready;
  assign first      = (count == '0);
  // the first term of a group sees the live acc_len, later terms the latched copy
  assign len_eff    = first ? acc_len : len_q;
  assign len_tgt    = (len_eff == '0) ? LEN_W'(1) : len_eff;
  assign last       = ({1'b0, count} + (LEN_W+1)'(1)) == {1'b0, len_tgt};
  assign busy       = (count != '0) || (state != ACC);

  assign rnd_bias = (shift_q == 5'd0) ? '0 : ((PW+1)'(1) << (shift_q - 5'd1));
  assign rnd_sum  = {product[PW-1], product} + rnd_bias;
  assign r        = rnd_sum >>> shift_q;
  assign clamp_hi = r > $signed((PW+1)'(127));
`ifdef PSUM_REQUANT_RELU_EN
  assign clamp_lo = r < $signed((PW+1)'(0));
`else
  assign clamp_lo = r < $signed(-(PW+1)'(128));
`endif
  // in range, low byte of r plus 128 mod 256 is exactly r + 128
  assign v8 = r[7:0] + 8'd128;

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:  if (accept && last) state_nxt = MUL;
      MUL:  state_nxt = RND;
      RND:  state_nxt = EMIT;
      EMIT: if (out_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      count     <= '0;
      len_q     <= '0;
      scale_q   <= '0;
      shift_q   <= '0;
      product   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
    end else if (clr) begin
      state     <= ACC;
      acc       <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ACC: if (accept) begin
          acc <= acc + ACC_W'(psum_in);
          if (first) begin
            len_q   <= acc_len;
            scale_q <= scale;
            shift_q <= shift;
          end
          count <= last ? '0 : count + LEN_W'(1);
        end
        MUL: product <= PW'(acc) * PW'($signed({1'b0, scale_q}));
        RND: begin
          out_valid <= 1'b1;
          if (clamp_hi) begin
            out_data <= 8'd255;
            sat      <= 1'b1;
          end else if (clamp_lo) begin
`ifdef PSUM_REQUANT_RELU_EN
            out_data <= 8'd128;
`else
            out_data <= 8'd0;
            sat      <= 1'b1;
`endif
          end else begin
            out_data <= v8;
          end
        end
        EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          acc       <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_requant.sv
// Scoreboard bench for psum_requant: expected bytes queued at stimulus time, popped at output handshake.
module tb_psum_requant;
  logic clk = 0, rst = 1, clr = 0;
  logic signed [31:0] psum_in = 0;
  logic psum_valid = 0, out_ready = 0;
  logic [7:0] acc_len = 1;
  logic [15:0] scale = 1;
  logic [4:0] shift = 0;
  logic psum_ready, out_valid, busy, sat;
  logic [7:0] out_data;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] sb[$];

  psum_requant dut (
    .clk(clk), .rst(rst), .clr(clr), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .acc_len(acc_len), .scale(scale), .shift(shift),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .sat(sat)
  );

  always #5 clk = ~clk;

  function automatic longint rq(longint sum, int sc, int sh);
    longint p, r;
    p = sum * sc;
    r = (sh == 0) ? p : ((p + (64'sd1 <<< (sh - 1))) >>> sh);
    return r + 128;
  endfunction

  function automatic logic [7:0] model(longint sum, int sc, int sh);
    longint v;
    v = rq(sum, sc, sh);
`ifdef PSUM_REQUANT_RELU_EN
    if (v < 128) return 8'd128;
`else
    if (v < 0) return 8'd0;
`endif
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  // Offer one term; bounded wait for psum_ready. Entered and left at a negedge.
  task automatic send(input int v);
    bit ok = 0;
    psum_in = v;
    psum_valid = 1;
    for (int i = 0; i < 40; i++) begin
      if (psum_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: psum_ready stayed %b, required 1", psum_ready);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    psum_valid = 0;
  endtask

  // Bounded wait for out_valid, then handshake; returns the data seen.
  task automatic get_out(output logic [7:0] d);
    bit ok = 0;
    d = 'x;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL out_timeout: out_valid stayed %b, required 1", out_valid);
    end else begin
      d = out_data;
      out_ready = 1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 0;
    end
  endtask

  task automatic pulse_clr();
    clr = 1;
    @(posedge clk);
    @(negedge clk);
    clr = 0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (psum_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", psum_ready); end
    n_cmp++; if ({out_valid, out_data, sat, busy} !== 11'd0) begin
      n_bad++; $display("FAIL rst_outs: got v=%b d=%0d sat=%b busy=%b want all 0", out_valid, out_data, sat, busy);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_cmp++; if (psum_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b want 1", psum_ready); end
  endtask

  task automatic test_latency();
    logic [7:0] exp;
    acc_len = 1; scale = 1; shift = 0;
    sb.push_back(model(5, 1, 0));
    psum_in = 5; psum_valid = 1;
    @(posedge clk);                       // edge N
    @(negedge clk); psum_valid = 0;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL lat_n: got v=%b busy=%b want v=0 busy=1", out_valid, busy);
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_n1: got v=%b want 0", out_valid); end
    @(negedge clk);
    exp = sb.pop_front();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== exp) begin
      n_bad++; $display("FAIL lat_n2: got v=%b d=%0d want v=1 d=%0d", out_valid, out_data, exp);
    end
    out_ready = 1;
    @(posedge clk);                       // edge N+3
    @(negedge clk); out_ready = 0;
    n_cmp++; if (psum_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL thru_n3: got rdy=%b v=%b busy=%b want 1 0 0", psum_ready, out_valid, busy);
    end
  endtask

  task automatic test_group();
    logic [7:0] d, exp;
    acc_len = 4; scale = 3; shift = 2;
    sb.push_back(model(40, 3, 2));
    send(10);
    acc_len = 1; scale = 99; shift = 7;   // must be ignored mid-group
    send(20); send(-5); send(15);
    get_out(d);
    exp = sb.pop_front();
    n_cmp++; if (d !== exp || exp !== 8'd158) begin n_bad++; $display("FAIL group4: got %0d want %0d", d, exp); end
  endtask

  task automatic test_sat();
    logic [7:0] d, exp;
    acc_len = 1; scale = 1; shift = 0;
    sb.push_back(model(1000, 1, 0));
    send(1000);
    get_out(d);
    exp = sb.pop_front();
    n_cmp++; if (d !== exp || sat !== 1'b1) begin n_bad++; $display("FAIL sat_hi: got d=%0d sat=%b want d=%0d sat=1", d, sat, exp); end
    send(0);
    get_out(d);
    n_cmp++; if (sat !== 1'b1) begin n_bad++; $display("FAIL sat_sticky: got %b want 1", sat); end
    pulse_clr();
    n_cmp++; if (sat !== 1'b0) begin n_bad++; $display("FAIL clr_sat: got %b want 0", sat); end
    sb.push_back(model(-1000, 1, 0));
    send(-1000);
    get_out(d);
    exp = sb.pop_front();
`ifdef PSUM_REQUANT_RELU_EN
    n_cmp++; if (d !== exp || sat !== 1'b0) begin n_bad++; $display("FAIL sat_lo: got d=%0d sat=%b want d=%0d sat=0", d, sat, exp); end
`else
    n_cmp++; if (d !== exp || sat !== 1'b1) begin n_bad++; $display("FAIL sat_lo: got d=%0d sat=%b want d=%0d sat=1", d, sat, exp); end
`endif
    pulse_clr();
  endtask

  task automatic test_backpressure();
    logic [7:0] d0, exp;
    acc_len = 1; scale = 2; shift = 1;
    sb.push_back(model(21, 2, 1));
    send(21);
    @(negedge clk); @(negedge clk);
    d0 = out_data;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== d0 || psum_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold%0d: got v=%b d=%0d rdy=%b want v=1 d=%0d rdy=0", i, out_valid, out_data, psum_ready, d0);
      end
      @(negedge clk);
    end
    exp = sb.pop_front();
    n_cmp++; if (d0 !== exp) begin n_bad++; $display("FAIL bp_data: got %0d want %0d", d0, exp); end
    out_ready = 1;
    @(posedge clk);
    @(negedge clk); out_ready = 0;
    n_cmp++; if (psum_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_release: got rdy=%b v=%b want 1 0", psum_ready, out_valid);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d, exp;
    acc_len = 4; scale = 1; shift = 0;
    send(7); send(9);
    rst = 1;
    #2;
    n_cmp++; if ({psum_ready, out_valid, out_data, sat, busy} !== 12'd0) begin
      n_bad++; $display("FAIL midrst_outs: got rdy=%b v=%b d=%0d sat=%b busy=%b want all 0", psum_ready, out_valid, out_data, sat, busy);
    end
    @(negedge clk); rst = 0;
    @(negedge clk);
    sb.push_back(model(4, 1, 0));
    for (int i = 0; i < 4; i++) send(1);
    get_out(d);
    exp = sb.pop_front();
    n_cmp++; if (d !== exp || exp !== 8'd132) begin n_bad++; $display("FAIL midrst_group: got %0d want %0d", d, exp); end
  endtask

  task automatic test_neg();
    logic [7:0] d, exp;
    acc_len = 0; scale = 1; shift = 0;    // length 0 behaves as 1
    sb.push_back(model(-10, 1, 0));
    send(-10);
    get_out(d);
    exp = sb.pop_front();
    n_cmp++; if (d !== exp || sat !== 1'b0) begin n_bad++; $display("FAIL neg10: got d=%0d sat=%b want d=%0d sat=0", d, sat, exp); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, exp;
    int len, sc, sh, v;
    longint sum;
    for (int g = 0; g < 6; g++) begin
      len = $urandom_range(5, 1); sc = $urandom_range(300, 0); sh = $urandom_range(12, 0);
      acc_len = 8'(len); scale = 16'(sc); shift = 5'(sh);
      sum = 0;
      for (int t = 0; t < len; t++) begin
        v = $urandom_range(2000, 0) - 1000;
        sum += v;
        send(v);
      end
      sb.push_back(model(sum, sc, sh));
      get_out(d);
      exp = sb.pop_front();
      n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL b2b_g%0d: got %0d want %0d", g, d, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_group();
    test_sat();
    test_backpressure();
    test_mid_reset();
    test_neg();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end
endmodule

// File: doc/psum_requant.md
PSUM_REQUANT -- requirements
Module: psum_requant

Interface
REQ-001 SHALL have parameter ACC_W, default 40, meaning signed accumulator width.
REQ-002 SHALL have parameter LEN_W, default 8, meaning width of acc_len.
REQ-003 SHALL have ports:
  clk  input  1  single clock, all state on rising edge.
  rst  input  1  asynchronous, active-high reset.
  clr  input  1  synchronous clear, same effect as reset.
  psum_in  input  32  signed PE partial sum (PE opsum).
  psum_valid  input  1  psum_in valid (PE valid).
  psum_ready  output  1  block accepts psum_in this cycle.
  acc_len  input  LEN_W  terms per output group; 0 treated as 1.
  scale  input  16  unsigned requant multiplier.
  shift  input  5  arithmetic right shift after multiply.
  out_data  output  8  unsigned activation, zero point 128.
  out_valid  output  1  out_data valid.
  out_ready  input  1  consumer accepts out_data.
  busy  output  1  group in progress or result pending.
  sat  output  1  sticky: some result clamped.

Function
REQ-004 SHALL implement FSM states ACC, MUL, RND, EMIT; reset state ACC.
REQ-005 psum_ready SHALL be 1 exactly when state is ACC and rst is low.
REQ-006 In ACC, accept when psum_valid and psum_ready both high: acc += sign-extended psum_in; count += 1.
REQ-007 acc_len, scale, shift SHALL be latched on the first accepted term of a group; later changes within the group SHALL be ignored.
REQ-008 When the accepted term brings count to the latched length: go to MUL; clear count.
REQ-009 MUL SHALL register product = acc * scale: signed, 57 bits, scale zero-extended; go to RND.
REQ-010 RND SHALL compute r = (product + 2^(shift-1)) >>> shift; with shift=0, r = product unrounded.
REQ-011 RND SHALL compute v = r + 128, clamp to [0,255], register into out_data, set out_valid, go to EMIT.
REQ-012 Any clamp SHALL set sat; sat SHALL stay high until rst or clr.
REQ-013 In EMIT, out_data and out_valid SHALL hold stable until out_ready is high.
REQ-014 On the out_valid && out_ready edge: clear out_valid and acc, go to ACC.
REQ-015 Latency: last term accepted at edge N -> out_valid high after edge N+2.
REQ-016 Throughput: with out_ready tied high, next psum_ready after edge N+3.
REQ-017 acc (ACC_W=40) SHALL NOT overflow for 255 terms of 32-bit input; no wrap handling required.
REQ-018 busy SHALL be high when count != 0 or state != ACC.
REQ-019 psum_valid while psum_ready is low SHALL be ignored; the upstream PE holds its data.

Reset
REQ-020 rst high SHALL asynchronously force state ACC, acc=0, count=0, out_data=0, out_valid=0, sat=0, psum_ready=0.
REQ-021 Reset mid-group SHALL discard partial sums; the first term after reset SHALL start a new group.
REQ-022 clr SHALL produce the REQ-020 state on the next edge, taking priority over any accept or handshake in that cycle.

Configuration
REQ-023 Macro PSUM_REQUANT_RELU_EN defined: lower clamp bound SHALL be 128 (ReLU at zero point).
REQ-024 Macro PSUM_REQUANT_RELU_EN defined: a clamp to 128 from below SHALL NOT set sat.
REQ-025 Macro PSUM_REQUANT_RELU_EN undefined: clamp range SHALL be [0,255].

Verification
REQ-026 acc_len=1, scale=1, shift=0, psum 5 -> out_data 133, out_valid 2 cycles after accept.
REQ-027 acc_len=4, scale=3, shift=2, psums 10,20,-5,15 -> sum 40, (120+2)>>>2=30 -> out_data 158.
REQ-028 acc_len=1, scale=1, shift=0, psum 1000 -> 255 with sat=1; after clr, psum -1000 -> 0 with sat=1 (macro undefined).
REQ-029 out_ready low for 5 cycles in EMIT -> out_data stable, psum_ready 0; out_ready high -> handshake, psum_ready 1 on next cycle.
REQ-030 acc_len=4, rst pulsed after 2 terms -> all outputs 0; then 4 terms of 1, scale=1, shift=0 -> out_data 132.
REQ-031 psum -10, scale=1, shift=0 -> out_data 128 and sat=0 with PSUM_REQUANT_RELU_EN defined; out_data 118 without.
